// File: rtl/channel_voice.sv
// Per-channel voice: NCO square oscillator, note-on detect, tick-driven volume envelope, volume-scaled PWM.
// Define CHANNEL_VOICE_ENVELOPE_EN for HOLD/DECAY; otherwise a note sustains at full volume until rest.
module channel_voice #(
    parameter int HOLD_TICKS  = 8,
    parameter int DECAY_TICKS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick_stb,
    input  logic [31:0] i_phase_delta,
    input  logic [7:0]  i_top,
    input  logic        i_top_valid,
    output logic        o_pwm,
    output logic        o_square,
    output logic [3:0]  o_volume,
    output logic        o_active
);

    if (HOLD_TICKS < 1 || HOLD_TICKS > 255 || DECAY_TICKS < 1 || DECAY_TICKS > 255) begin : g_bad_param
        $error("channel_voice: HOLD_TICKS and DECAY_TICKS must be in 1..255");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DECAY   = 2'd2;
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] DECAY_LAST = 8'(DECAY_TICKS - 1);
`else
    localparam logic [1:0] ST_SUSTAIN = 2'd3;
`endif

    logic [31:0] phase_q, phase_d;
    logic [31:0] last_delta_q, last_delta_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  volume_q, volume_d;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
    logic [7:0]  tick_cnt_q, tick_cnt_d;
`else
    logic        unused_tick;
    assign unused_tick = i_tick_stb;
`endif
    logic [7:0]  top_q, top_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [8:0]  duty_q, duty_d;
    logic        pwm_q, pwm_d;
    logic        note_on;
    logic        rest;
    logic        square;
    logic [12:0] duty_prod;

    assign rest    = (i_phase_delta == 32'd0);
    assign note_on = (i_phase_delta != last_delta_q) && !rest;
    assign square  = (state_q != ST_IDLE) && phase_q[31];

    // Note-on beats rest and any coincident tick; ticks only matter while a note plays.
    always_comb begin
        phase_d      = phase_q;
        last_delta_d = i_phase_delta;
        state_d      = state_q;
        volume_d     = volume_q;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
        tick_cnt_d   = tick_cnt_q;
`endif
        if (note_on) begin
            phase_d  = 32'd0;
            volume_d = 4'd15;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
            tick_cnt_d = 8'd0;
            state_d    = ST_HOLD;
`else
            state_d    = ST_SUSTAIN;
`endif
        end else if (rest) begin
            state_d  = ST_IDLE;
            volume_d = 4'd0;
        end else begin
            phase_d = phase_q + i_phase_delta;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
            if (i_tick_stb) begin
                case (state_q)
                    ST_HOLD: begin
                        if (tick_cnt_q == HOLD_LAST) begin
                            tick_cnt_d = 8'd0;
                            state_d    = ST_DECAY;
                        end else begin
                            tick_cnt_d = tick_cnt_q + 8'd1;
                        end
                    end
                    ST_DECAY: begin
                        if (tick_cnt_q == DECAY_LAST) begin
                            tick_cnt_d = 8'd0;
                            if (volume_q <= 4'd1) begin
                                volume_d = 4'd0;
                                state_d  = ST_IDLE;
                            end else begin
                                volume_d = volume_q - 4'd1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
`endif
        end
    end

    // Top and duty only move at the period wrap so a period never glitches.
    assign duty_prod = (13'(top_q) + 13'd1) * 13'(volume_q);

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        top_d     = top_q;
        duty_d    = duty_q;
        if (pwm_cnt_q == top_q) begin
            pwm_cnt_d = 8'd0;
            duty_d    = duty_prod[12:4];
            if (i_top_valid) begin
                top_d = i_top;
            end
        end
        pwm_d = square && ({1'b0, pwm_cnt_q} < duty_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q      <= 32'd0;
            last_delta_q <= 32'd0;
            state_q      <= ST_IDLE;
            volume_q     <= 4'd0;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
            tick_cnt_q   <= 8'd0;
`endif
            top_q        <= 8'hff;
            pwm_cnt_q    <= 8'd0;
            duty_q       <= 9'd0;
            pwm_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            last_delta_q <= last_delta_d;
            state_q      <= state_d;
            volume_q     <= volume_d;
`ifdef CHANNEL_VOICE_ENVELOPE_EN
            tick_cnt_q   <= tick_cnt_d;
`endif
            top_q        <= top_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
        end
    end

    assign o_pwm    = pwm_q;
    assign o_square = square;
    assign o_volume = volume_q;
    assign o_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_channel_voice.sv
// Directed bench for channel_voice: reset, square timing, envelope/sustain, retrigger, rest, PWM scaling.
module tb_channel_voice;

    logic        clk;
    logic        i_rst;
    logic        i_tick_stb;
    logic [31:0] i_phase_delta;
    logic [7:0]  i_top;
    logic        i_top_valid;
    logic        o_pwm;
    logic        o_square;
    logic [3:0]  o_volume;
    logic        o_active;

    int vectors = 0;
    int miscompares = 0;
    int c;

    channel_voice #(
        .HOLD_TICKS  (2),
        .DECAY_TICKS (1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_tick_stb    (i_tick_stb),
        .i_phase_delta (i_phase_delta),
        .i_top         (i_top),
        .i_top_valid   (i_top_valid),
        .o_pwm         (o_pwm),
        .o_square      (o_square),
        .o_volume      (o_volume),
        .o_active      (o_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick strobe after nine idle cycles; returns at the negedge after the strobe edge.
    task automatic tick();
        repeat (9) @(negedge clk);
        i_tick_stb = 1'b1;
        @(negedge clk);
        i_tick_stb = 1'b0;
    endtask

    task automatic count_pwm(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            cnt += int'(o_pwm);
        end
    endtask

    initial begin
        i_rst         = 1'b1;
        i_tick_stb    = 1'b0;
        i_phase_delta = 32'd0;
        i_top         = 8'hff;
        i_top_valid   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", o_pwm, 0);
        check("rst_square", o_square, 0);
        check("rst_volume", o_volume, 0);
        check("rst_active", o_active, 0);

        // Start a note, then reset in the middle of it.
        i_rst         = 1'b0;
        i_phase_delta = 32'h1000_0000;
        repeat (20) @(negedge clk);
        check("note_active", o_active, 1);
        check("note_volume", o_volume, 15);
        #2;
        i_rst         = 1'b1;
        i_phase_delta = 32'd0;
        #1;
        check("midrst_pwm", o_pwm, 0);
        check("midrst_square", o_square, 0);
        check("midrst_volume", o_volume, 0);
        check("midrst_active", o_active, 0);
        @(negedge clk);
        check("rsthold_active", o_active, 0);

        // Square: low 8 clocks, high 8 clocks after note-on.
        i_rst         = 1'b0;
        i_top         = 8'hff;
        i_top_valid   = 1'b1;
        i_phase_delta = 32'h1000_0000;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("square_k%0d", k), o_square, (k >= 9) ? 1 : 0);
        end
        check("square_volume", o_volume, 15);
        check("square_active", o_active, 1);

`ifdef CHANNEL_VOICE_ENVELOPE_EN
        // Envelope: two hold ticks at 15, then one step per tick down to idle at tick 17.
        for (int j = 1; j <= 17; j++) begin
            tick();
            check($sformatf("env_tick%0d", j), o_volume, (j <= 2) ? 15 : (17 - j));
        end
        check("env_end_active", o_active, 0);
        check("env_end_square", o_square, 0);

        // Retrigger in the middle of decay at volume 5.
        i_phase_delta = 32'h2000_0000;
        @(negedge clk);
        check("retrig_on_volume", o_volume, 15);
        for (int j = 1; j <= 12; j++) tick();
        check("retrig_pre_volume", o_volume, 5);
        i_phase_delta = 32'h1000_0000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("retrig_volume", o_volume, 15);
                check("retrig_active", o_active, 1);
                check("retrig_square_k1", o_square, 0);
            end
            if (k == 8) check("retrig_square_k8", o_square, 0);
            if (k == 9) check("retrig_square_k9", o_square, 1);
        end
        tick();
        check("retrig_hold1", o_volume, 15);
        tick();
        check("retrig_hold2", o_volume, 15);
        tick();
        check("same_delta_no_retrig", o_volume, 14);

        i_phase_delta = 32'd0;
        @(negedge clk);
        check("rest_active", o_active, 0);
        check("rest_volume", o_volume, 0);

        // Note-on together with a tick: the tick must not count toward hold.
        i_phase_delta = 32'h3000_0000;
        i_tick_stb    = 1'b1;
        @(negedge clk);
        i_tick_stb    = 1'b0;
        check("simul_volume", o_volume, 15);
        tick();
        check("simul_tick1", o_volume, 15);
        tick();
        check("simul_tick2", o_volume, 15);
        tick();
        check("simul_tick3", o_volume, 14);
        i_phase_delta = 32'd0;
        @(negedge clk);
        check("simul_rest_active", o_active, 0);
`else
        // Sustain: ticks are ignored, volume stays 15 until rest.
        i_phase_delta = 32'h3000_0000;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            i_tick_stb = (i % 3 == 0);
            @(negedge clk);
            if (i % 20 == 19) check($sformatf("sustain_i%0d", i), o_volume, 15);
        end
        i_tick_stb = 1'b0;
        check("sustain_active", o_active, 1);
        i_phase_delta = 32'd0;
        @(negedge clk);
        check("sustain_rest_volume", o_volume, 0);
        check("sustain_rest_active", o_active, 0);
`endif

        // PWM: latch top=15 while resting, then play a slow note at full volume.
        i_top       = 8'd15;
        i_top_valid = 1'b1;
        repeat (300) @(negedge clk);
        count_pwm(16, c);
        check("pwm_rest", c, 0);
        i_phase_delta = 32'h0080_0000;
        repeat (50) @(negedge clk);
        count_pwm(16, c);
        check("pwm_square_low", c, 0);
        repeat (234) @(negedge clk);
        check("pwm_square_high", o_square, 1);
        count_pwm(16, c);
        check("pwm_top15", c, 15);
        i_top = 8'd7;
        repeat (40) @(negedge clk);
        count_pwm(8, c);
        check("pwm_top7_8", c, 7);
        count_pwm(16, c);
        check("pwm_top7_16", c, 14);
        i_top = 8'd0;
        repeat (20) @(negedge clk);
        count_pwm(16, c);
        check("pwm_top0", c, 0);
        check("pwm_top0_square", o_square, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
